// File: rtl/mdu_iterative.sv
// Iterative-latency multiply/divide unit owning HI/LO. The result is computed at
// issue, held in pending registers, and committed after the class latency elapses.
module mdu_iterative #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             int_exc_req,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   hi_n, lo_n, pend_hi, pend_lo, pend_hi_n, pend_lo_n;
    logic               accept, sgn_mul;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, dvd, dvs, uq, ur, sq, sr;

    assign accept = start & ~int_exc_req & (state == IDLE);
    assign busy   = (state == RUN);

    // Sign/zero-extend to 2*WIDTH so one unsigned multiply gives the exact
    // product modulo 2^(2*WIDTH) for both signed and unsigned forms.
    assign sgn_mul = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    assign a_ext   = sgn_mul ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
    assign b_ext   = sgn_mul ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
    assign prod    = a_ext * b_ext;

    // Signed divide via magnitudes; the overflow case falls out naturally since
    // |min| is representable unsigned and both signs match.
    assign a_neg = (op == OP_DIV) & rs[WIDTH-1];
    assign b_neg = (op == OP_DIV) & rt[WIDTH-1];
    assign a_mag = a_neg ? -rs : rs;
    assign b_mag = b_neg ? -rt : rt;
    assign dvd   = a_mag;
    assign dvs   = (rt == '0) ? WIDTH'(1) : b_mag;
    assign uq    = dvd / dvs;
    assign ur    = dvd % dvs;
    assign sq    = (a_neg ^ b_neg) ? -uq : uq;
    assign sr    = a_neg ? -ur : ur;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hi_n      = hi;
        lo_n      = lo;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        acc       = {hi, lo};
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MTHI: hi_n = rs;
                        OP_MTLO: lo_n = rs;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            if (op == OP_MADD || op == OP_MADDU)
                                acc = {hi, lo} + prod;
                            else if (op == OP_MSUB || op == OP_MSUBU)
                                acc = {hi, lo} - prod;
                            else
                                acc = prod;
                            {pend_hi_n, pend_lo_n} = acc;
                            cnt_n   = MULT_LOAD;
                            state_n = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still occupies the unit but leaves HI/LO intact.
                            if (rt == '0) begin
                                pend_hi_n = hi;
                                pend_lo_n = lo;
                            end else begin
                                pend_hi_n = sr;
                                pend_lo_n = sq;
                            end
                            cnt_n   = DIV_LOAD;
                            state_n = RUN;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    hi_n    = pend_hi;
                    lo_n    = pend_lo;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi      <= hi_n;
            lo      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomized and directed checks of mdu_iterative against an arithmetic
// reference model of HI/LO and the per-class busy latency.
module tb_mdu_iterative;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 0;
    logic         reset = 1;
    logic         start = 0;
    logic [3:0]   op = 0;
    logic [W-1:0] rs = 0, rt = 0;
    logic         int_exc_req = 0;
    logic         busy;
    logic [W-1:0] hi, lo;

    int pass_cnt = 0;
    int total = 0;
    logic [W-1:0] m_hi = 0, m_lo = 0;

    mdu_iterative #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .int_exc_req(int_exc_req), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic int exp_cycles(input logic [3:0] o, input bit exc);
        if (exc) return 0;
        if (o == 2 || o == 3) return DC;
        if (o <= 7) return MC;
        return 0;
    endfunction

    task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit exc);
        longint sa, sb, q, r;
        logic [63:0] acc, p;
        if (exc) return;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {m_hi, m_lo};
        case (o)
            0: {m_hi, m_lo} = sa * sb;
            1: {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
            2: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            4: begin p = sa * sb; {m_hi, m_lo} = acc + p; end
            5: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = acc + p; end
            6: begin p = sa * sb; {m_hi, m_lo} = acc - p; end
            7: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = acc - p; end
            8: m_hi = a;
            9: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one request and count busy cycles, bounded.
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit exc, output int ncyc);
        start = 1; op = o; rs = a; rt = b; int_exc_req = exc;
        @(posedge clk); #1;
        start = 0; int_exc_req = 0;
        ncyc = 0;
        while (busy === 1'b1 && ncyc < 200) begin
            ncyc++;
            @(posedge clk); #1;
        end
        model(o, a, b, exc);
    endtask

    task automatic check_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit exc);
        int n;
        do_op(o, a, b, exc, n);
        total++;
        if (n !== exp_cycles(o, exc))
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, exp_cycles(o, exc));
        else pass_cnt++;
        total++;
        if (hi !== m_hi || lo !== m_lo)
            $display("FAIL %s hilo got=%h_%h exp=%h_%h op=%0d rs=%h rt=%h",
                     name, hi, lo, m_hi, m_lo, o, a, b);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        reset = 1;
        @(posedge clk); @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0)
            $display("FAIL reset got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
        else pass_cnt++;
        reset = 0;
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_mult;
        check_op("mult_neg", 0, 32'hFFFFFFFE, 32'd3, 0);
        total++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA)
            $display("FAIL mult_const got=%h_%h exp=ffffffff_fffffffa", hi, lo);
        else pass_cnt++;
        check_op("multu", 1, 32'hFFFFFFFF, 32'd2, 0);
        total++;
        if (hi !== 32'h1 || lo !== 32'hFFFFFFFE)
            $display("FAIL multu_const got=%h_%h exp=00000001_fffffffe", hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_div;
        check_op("div_neg", 2, 32'hFFFFFFF9, 32'd2, 0);
        total++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
            $display("FAIL div_const got=%h_%h exp=ffffffff_fffffffd", hi, lo);
        else pass_cnt++;
        check_op("div_ovf", 2, 32'h80000000, 32'hFFFFFFFF, 0);
        total++;
        if (hi !== 32'h0 || lo !== 32'h80000000)
            $display("FAIL div_ovf_const got=%h_%h exp=00000000_80000000", hi, lo);
        else pass_cnt++;
        check_op("divu", 3, 32'd1000, 32'd7, 0);
        check_op("divu_zero", 3, 32'd55, 32'd0, 0);
        check_op("div_zero", 2, 32'hF0000000, 32'd0, 0);
    endtask

    task automatic test_madd;
        check_op("mthi", 8, 32'h12345678, 32'd0, 0);
        check_op("mtlo", 9, 32'd1, 32'd0, 0);
        check_op("madd", 4, 32'd2, 32'd3, 0);
        total++;
        if (hi !== 32'h12345678 || lo !== 32'd7)
            $display("FAIL madd_const got=%h_%h exp=12345678_00000007", hi, lo);
        else pass_cnt++;
        check_op("msub", 6, 32'hFFFFFFFF, 32'd9, 0);
        check_op("msubu", 7, 32'hFFFFFFFF, 32'd9, 0);
        check_op("maddu", 5, 32'h80000001, 32'h80000001, 0);
    endtask

    task automatic test_int_exc;
        check_op("mult_exc", 0, 32'd11, 32'd13, 1);
        check_op("mtlo_exc", 9, 32'hDEADBEEF, 32'd0, 1);
        check_op("mthi_exc", 8, 32'hCAFEF00D, 32'd0, 1);
    endtask

    task automatic test_exc_in_run;
        int n;
        start = 1; op = 2; rs = 32'd100; rt = 32'hFFFFFFFD;
        @(posedge clk); #1;
        start = 0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            int_exc_req = (n == 3);
            @(posedge clk); #1;
        end
        int_exc_req = 0;
        model(2, 32'd100, 32'hFFFFFFFD, 0);
        total++;
        if (n !== DC) $display("FAIL exc_in_run busy_cycles got=%0d exp=%0d", n, DC);
        else pass_cnt++;
        total++;
        if (hi !== m_hi || lo !== m_lo)
            $display("FAIL exc_in_run hilo got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop;
        check_op("pre_mthi", 8, 32'hA5A5A5A5, 32'd0, 0);
        check_op("pre_mtlo", 9, 32'h5A5A5A5A, 32'd0, 0);
        start = 1; op = 0; rs = 32'd7; rt = 32'd9;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #2;
        reset = 1;
        #1;
        total++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0)
            $display("FAIL reset_midop got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 0;
        m_hi = 0; m_lo = 0;
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0)
            $display("FAIL reset_no_commit got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [3:0]   o;
        logic [W-1:0] a, b;
        bit           exc;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 5));
                default: ;
            endcase
            exc = ($urandom_range(0, 7) == 0);
            check_op("random", o, a, b, exc);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_madd();
        test_int_exc();
        test_exc_in_run();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
